// File: rtl/bcd_pkg.sv
// Shared types and sizing for the 4-digit BCD to 14-bit binary converter.
//   state_e     : converter FSM states (IDLE, SHIFT, DONE)
//   BIN_W       : width of the binary result
//   BCD_DIGITS  : number of BCD input digits
//   SHIFT_ITERS : number of shift/adjust cycles per conversion
package bcd_pkg;

  localparam int unsigned BIN_W       = 14;
  localparam int unsigned BCD_DIGITS  = 4;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned BCD_W       = BCD_DIGITS * DIGIT_W;
  localparam int unsigned SHIFT_ITERS = 14;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Per-digit correction step of reverse double-dabble.
//   digit_i : BCD digit after the right shift
//   digit_o : digit_i - 3 when digit_i >= 8, otherwise digit_i
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= DIGIT_W'(8)) begin
      digit_o = digit_i - DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bcd_to_binary_fourteen_bit.sv
// Sequential 4-digit BCD to 14-bit binary converter (reverse double-dabble).
// A start in IDLE captures the digits; 14 shift/adjust cycles follow, then
// a DONE state registers the result. done pulses for one cycle with out/err
// valid; out/err hold until the next done.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   start                           : conversion request, sampled in IDLE only
//   thousands, hundreds, tens, ones : BCD digits, captured on accepted start
//   busy                            : high in SHIFT and DONE
//   done                            : one-cycle result-valid pulse
//   out                             : binary result
//   err                             : invalid-digit flag
// Optional feature macro: BCD_INPUT_CHECK_EN -- when defined, a start with any
// digit above 9 bypasses SHIFT and reports out=0, err=1. When undefined, err
// is tied low and no checking logic exists.
module bcd_to_binary_fourteen_bit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       thousands,
  input  logic [3:0]       hundreds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic             busy,
  output logic             done,
  output logic [BIN_W-1:0] out,
  output logic             err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SHIFT_ITERS - 1);

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   out_q, out_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   bcd_shift;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BIN_W-1:0]   bin_shift;

  // One combined right shift of {bcd, bin}; the BCD LSB falls into bin MSB.
  assign bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
  assign bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (bcd_shift[g*DIGIT_W +: DIGIT_W]),
      .digit_o (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BCD_INPUT_CHECK_EN
  logic bad_q, bad_d;
  logic err_q, err_d;
  logic in_bad;

  assign in_bad = (thousands > 4'd9) || (hundreds > 4'd9) ||
                  (tens > 4'd9) || (ones > 4'd9);
`endif

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
`ifdef BCD_INPUT_CHECK_EN
    bad_d   = bad_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = {thousands, hundreds, tens, ones};
          bin_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef BCD_INPUT_CHECK_EN
          bad_d   = in_bad;
          // bin stays cleared, so the DONE path naturally yields out=0.
          if (in_bad) begin
            state_d = DONE;
          end
`endif
        end
      end

      SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = bin_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
      end

      DONE: begin
        out_d   = bin_q;
        done_d  = 1'b1;
`ifdef BCD_INPUT_CHECK_EN
        err_d   = bad_q;
`endif
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

`ifdef BCD_INPUT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      bad_q <= bad_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_bcd_to_binary_fourteen_bit.sv
module tb_bcd_to_binary_fourteen_bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic        busy;
  logic        done;
  logic [13:0] out;
  logic        err;

  int unsigned n_checks;
  int unsigned n_errors;

  bcd_to_binary_fourteen_bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one start from IDLE and wait (bounded) for done.
  // lat = number of rising edges after the start edge until done is seen.
  task automatic run_conv(input logic [3:0] d3, input logic [3:0] d2,
                          input logic [3:0] d1, input logic [3:0] d0,
                          output logic [13:0] res, output logic e,
                          output int lat);
    @(negedge clk);
    thousands = d3; hundreds = d2; tens = d1; ones = d0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 99;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    res = out;
    e   = err;
  endtask

  typedef struct {
    logic [3:0]  d3, d2, d1, d0;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [13:0] res;
    logic        e;
    int          lat;
    int          ndone;
    logic [13:0] seen;
    int          first_done, second_done;

    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    thousands = 4'd0; hundreds = 4'd0; tens = 4'd0; ones = 4'd0;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out",  out,  0);
    check("rst_err",  err,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    vecs.push_back('{4'd9, 4'd9, 4'd9, 4'd9, 14'd9999});
    vecs.push_back('{4'd0, 4'd0, 4'd0, 4'd0, 14'd0});
    vecs.push_back('{4'd1, 4'd2, 4'd3, 4'd4, 14'd1234});
    vecs.push_back('{4'd0, 4'd0, 4'd0, 4'd7, 14'd7});
    vecs.push_back('{4'd8, 4'd1, 4'd9, 4'd2, 14'd8192});
    vecs.push_back('{4'd1, 4'd0, 4'd0, 4'd0, 14'd1000});
    vecs.push_back('{4'd0, 4'd0, 4'd9, 4'd9, 14'd99});
    vecs.push_back('{4'd5, 4'd0, 4'd0, 4'd5, 14'd5005});
    vecs.push_back('{4'd0, 4'd0, 4'd4, 4'd2, 14'd42});
    foreach (vecs[k]) begin
      run_conv(vecs[k].d3, vecs[k].d2, vecs[k].d1, vecs[k].d0, res, e, lat);
      check("dir_out", res, vecs[k].exp);
      check("dir_err", e, 0);
      check("dir_lat", lat, 15);
    end

    // Round trip over a spread of values
    for (int v = 0; v <= 9999; v += 41) begin
      run_conv(4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10),
               res, e, lat);
      check("rt_out", res, v);
    end
    run_conv(4'd9, 4'd9, 4'd9, 4'd8, res, e, lat);
    check("rt_9998", res, 9998);

    // Starts while busy are ignored, digit changes mid-run have no effect
    @(negedge clk);
    thousands = 4'd3; hundreds = 4'd0; tens = 4'd5; ones = 4'd8;
    start = 1'b1;
    @(posedge clk);                      // edge N
    #1 start = 1'b0;
    repeat (2) @(posedge clk);           // edge N+2
    #1;
    check("busy_shift", busy, 1);
    start = 1'b1;
    thousands = 4'd9; hundreds = 4'd9; tens = 4'd9; ones = 4'd9;
    @(posedge clk);                      // edge N+3
    #1 start = 1'b0;
    repeat (5) @(posedge clk);           // edge N+8
    #1 start = 1'b1;
    thousands = 4'd6; hundreds = 4'd6; tens = 4'd1; ones = 4'd1;
    @(posedge clk);                      // edge N+9
    #1 start = 1'b0;
    ndone = 0;
    seen = '0;
    first_done = 0;
    for (int i = 10; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        seen = out;
        if (first_done == 0) first_done = i;
      end
    end
    check("ign_ndone", ndone, 1);
    check("ign_out",   seen,  3058);
    check("ign_when",  first_done, 15);

    // start held high: back-to-back conversions every 16 cycles
    @(negedge clk);
    thousands = 4'd2; hundreds = 4'd0; tens = 4'd2; ones = 4'd5;
    start = 1'b1;
    first_done = 0;
    second_done = 0;
    seen = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = out;
        if (first_done == 0) first_done = i;
        else if (second_done == 0) second_done = i;
      end
    end
    start = 1'b0;
    check("b2b_first",  first_done, 15);
    check("b2b_period", second_done - first_done, 16);
    check("b2b_out",    seen, 2025);
    repeat (20) @(posedge clk);

    // Reset during SHIFT: abort, no done, out back to 0
    run_conv(4'd4, 4'd3, 4'd2, 4'd1, res, e, lat);
    check("pre_rst_out", res, 4321);
    @(negedge clk);
    thousands = 4'd5; hundreds = 4'd6; tens = 4'd7; ones = 4'd8;
    start = 1'b1;
    @(posedge clk);                      // edge N
    #1 start = 1'b0;
    repeat (7) @(posedge clk);           // edge N+7
    #1 rst_n = 1'b0;
    #1;
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    check("ab_out",  out,  0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("ab_ndone", ndone, 0);
    check("ab_out_hold", out, 0);
    run_conv(4'd0, 4'd0, 4'd4, 4'd2, res, e, lat);
    check("post_rst_out", res, 42);
    check("post_rst_lat", lat, 15);

    // Invalid digit handling
    run_conv(4'd1, 4'hA, 4'd0, 4'd0, res, e, lat);
`ifdef BCD_INPUT_CHECK_EN
    check("inv_lat", lat, 1);
    check("inv_out", res, 0);
    check("inv_err", e, 1);
`else
    check("inv_lat", lat, 15);
    check("inv_err", e, 0);
`endif
    run_conv(4'd0, 4'd0, 4'd4, 4'd2, res, e, lat);
    check("inv_next_out", res, 42);
    check("inv_next_err", e, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_fourteen_bit.md
BCD_TO_BINARY_FOURTEEN_BIT -- requirements
Module: bcd_to_binary_fourteen_bit

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  input  1  request conversion; sampled only in IDLE.
REQ-004 SHALL have ports: thousands, hundreds, tens, ones  input  4 each  BCD digits, captured on accepted start.
REQ-005 SHALL have port: busy  output  1  high in every state other than IDLE.
REQ-006 SHALL have port: done  output  1  one-cycle pulse; out and err valid in that cycle.
REQ-007 SHALL have port: out  output  14  binary result, held until the next done.
REQ-008 SHALL have port: err  output  1  invalid-digit flag, held with out (see Configuration).

Function
REQ-009 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-010 IDLE: start=1 SHALL load a 16-bit BCD register {thousands,hundreds,tens,ones}, clear the 14-bit shift register and the 4-bit iteration counter, and enter SHIFT.
REQ-011 SHIFT: each cycle SHALL shift {bcd_reg,bin_reg} right by 1, then subtract 3 from every 4-bit BCD digit that is >=8 after the shift (reverse double-dabble).
REQ-012 SHIFT SHALL last exactly 14 cycles; the counter increments per cycle; on count 13, next state is DONE.
REQ-013 DONE: done=1 for exactly one cycle, out<=bin_reg, err updated; next state always IDLE.
REQ-014 Latency: start sampled at edge N -> done high in the cycle after edge N+15; next start accepted at edge N+16.
REQ-015 start while busy (SHIFT or DONE) SHALL be ignored and not queued; input digit changes while busy SHALL NOT affect the result.
REQ-016 For all valid inputs 0000..9999, out SHALL equal 1000*thousands+100*hundreds+10*tens+ones; no overflow (max 9999 < 2^14).
REQ-017 start held high continuously SHALL produce back-to-back conversions every 16 cycles.

Reset
REQ-018 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, out=0, err=0, counter=0, working registers=0.
REQ-019 Reset mid-SHIFT SHALL abort the conversion with no done pulse; out keeps reset value 0.
REQ-020 After rst_n deasserts, first start SHALL be accepted on the first rising edge where it is high.

Configuration
REQ-021 Macro BCD_INPUT_CHECK_EN SHALL gate input checking.
REQ-022 Defined: on accepted start, any digit >9 SHALL skip SHIFT, go IDLE->DONE directly (done one cycle after the start edge), out=0, err=1; valid inputs give err=0.
REQ-023 Not defined: no check logic; err SHALL be constant 0; invalid digits give an unspecified out but the normal 15-cycle timing.

Structure
REQ-024 Package bcd_pkg SHALL hold: state enum (IDLE, SHIFT, DONE), BIN_W=14, BCD_DIGITS=4, SHIFT_ITERS=14.
REQ-025 Sub-module bcd_digit_adjust (4-bit in/out, subtract 3 if >=8) SHALL be instantiated once per digit.

Verification
REQ-026 Digits 9,9,9,9 + start pulse -> done 15 cycles after start edge, out=9999, err=0.
REQ-027 Digits 0,0,0,0 -> out=0; digits 1,2,3,4 -> out=1234; digits 0,0,0,7 -> out=7.
REQ-028 Round trip: drive all 0..9999 through binary_to_BCD_fourteen_bit into this block -> out equals original value every time.
REQ-029 start pulsed at cycles +3 and +9 after an accepted start, digits changed mid-run -> exactly one done, result of original digits.
REQ-030 rst_n low at cycle +7 of a conversion -> no done, out=0, busy=0; next start converts normally.
REQ-031 With BCD_INPUT_CHECK_EN: digits 1,A,0,0 -> done one cycle after start, out=0, err=1; following 0,0,4,2 -> out=42, err=0.
